// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial sample inputs and match/status outputs of the pattern detector.
interface seq_detect_param_if #(parameter int CNT_W = 8);
  logic en;
  logic in;
  logic clear_cnt;
  logic match;
  logic [CNT_W-1:0] match_cnt;
  logic [4:0] fill;
  modport master(output en, in, clear_cnt, input match, match_cnt, fill);
  modport slave(input en, in, clear_cnt, output match, match_cnt, fill);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with overlap/Mealy-Moore options and saturating match counter.
module seq_detect_param #(
  parameter int N = 3,
  parameter logic [N-1:0] PATTERN = 3'b110,
  parameter bit OVERLAP = 1'b1,
  parameter bit MOORE = 1'b0,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  seq_detect_param_if.slave bus
);
  logic [N-1:0] hist_q, hist_d, shifted;
  logic [4:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic match_q, match_d, hit;
  always_comb begin
    shifted = N'({hist_q, bus.in});
    hit = bus.en & ~rst & (fill_q >= 5'(N - 1)) & (shifted == PATTERN);
    hist_d = bus.en ? shifted : hist_q;
    fill_d = !bus.en ? fill_q
           : (hit && !OVERLAP) ? 5'd0
           : (fill_q == 5'(N)) ? fill_q : fill_q + 5'd1;
    // a clear coinciding with a hit keeps that hit
    cnt_d = hit ? (bus.clear_cnt ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1)))
                : (bus.clear_cnt ? '0 : cnt_q);
    match_d = hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end
  assign bus.match     = MOORE ? match_q : hit;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: five detector configurations on one shared stream, checked against a sample-history model.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, din = 1'b0, clr = 1'b0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8)) if0 ();
  seq_detect_param_if #(.CNT_W(8)) if1 ();
  seq_detect_param_if #(.CNT_W(8)) if2 ();
  seq_detect_param_if #(.CNT_W(2)) if3 ();
  seq_detect_param_if #(.CNT_W(4)) if4 ();

  seq_detect_param #(.N(3), .PATTERN(3'b110), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
    d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8))
    d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_detect_param #(.N(3), .PATTERN(3'b110), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8))
    d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2))
    d3 (.clk(clk), .rst(rst), .bus(if3.slave));
  seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(4))
    d4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign {if0.en, if0.in, if0.clear_cnt} = {en, din, clr};
  assign {if1.en, if1.in, if1.clear_cnt} = {en, din, clr};
  assign {if2.en, if2.in, if2.clear_cnt} = {en, din, clr};
  assign {if3.en, if3.in, if3.clear_cnt} = {en, din, clr};
  assign {if4.en, if4.in, if4.clear_cnt} = {en, din, clr};

  int g_m[5], g_c[5], g_f[5];
  assign g_m[0] = int'(if0.match); assign g_c[0] = int'(if0.match_cnt); assign g_f[0] = int'(if0.fill);
  assign g_m[1] = int'(if1.match); assign g_c[1] = int'(if1.match_cnt); assign g_f[1] = int'(if1.fill);
  assign g_m[2] = int'(if2.match); assign g_c[2] = int'(if2.match_cnt); assign g_f[2] = int'(if2.fill);
  assign g_m[3] = int'(if3.match); assign g_c[3] = int'(if3.match_cnt); assign g_f[3] = int'(if3.fill);
  assign g_m[4] = int'(if4.match); assign g_c[4] = int'(if4.match_cnt); assign g_f[4] = int'(if4.fill);

  // configuration table: length, pattern, overlap, moore, counter width
  int pn[5] = '{3, 3, 3, 3, 4};
  int pp[5] = '{6, 5, 6, 5, 11};
  int po[5] = '{1, 0, 1, 1, 0};
  int pm[5] = '{0, 0, 1, 0, 1};
  int pw[5] = '{8, 8, 8, 2, 4};

  // model: samples taken since last reset/discard, all sample bits, count, delayed hit
  int seen[5] = '{default: 0};
  int sh[5] = '{default: 0};
  int cnt[5] = '{default: 0};
  int mreg[5] = '{default: 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic b, input logic c);
    int hitm[5];
    rst = r; en = e; din = b; clr = c;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      int mask = (1 << pn[k]) - 1;
      hitm[k] = int'(e && !r && seen[k] >= pn[k] - 1 && ((((sh[k] << 1) | int'(b)) & mask) == pp[k]));
      chk($sformatf("d%0d_match", k), g_m[k], pm[k] != 0 ? mreg[k] : hitm[k]);
      chk($sformatf("d%0d_fill", k), g_f[k], seen[k] < pn[k] ? seen[k] : pn[k]);
      chk($sformatf("d%0d_cnt", k), g_c[k], cnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      int cmax = (1 << pw[k]) - 1;
      if (r) begin
        seen[k] = 0; sh[k] = 0; cnt[k] = 0; mreg[k] = 0;
      end else begin
        if (e) begin
          sh[k] = (sh[k] << 1) | int'(b);
          seen[k] = (hitm[k] != 0 && po[k] == 0) ? 0 : seen[k] + 1;
        end
        cnt[k] = hitm[k] != 0 ? (c ? 1 : (cnt[k] == cmax ? cnt[k] : cnt[k] + 1)) : (c ? 0 : cnt[k]);
        mreg[k] = hitm[k];
      end
    end
    #1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b110, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b10101, 5);
    chk("ov0_cnt", g_c[1], 1);
    chk("ov0_fill", g_f[1], 2);
    chk("ov1_cnt", g_c[3], 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_cnt", g_c[0], 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b11, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_fill", g_f[0], 1);
    chk("rst_cnt", g_c[0], 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b101010101, 9);
    chk("sat_cnt", g_c[3], 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_hit_cnt", g_c[3], 1);
    for (int i = 0; i < 600; i++)
      step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 29) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
